// File: rtl/rv_ctrl_pkg.sv
// Shared constants for the multi-cycle RISC-V control FSM: opcodes, state and class encodings, alu_op codes.
// The JAL class is only legal when RV_CTRL_JAL_EN is defined.
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_FAULT  = 3'd5;

    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_R      = 3'd1,
        CLS_I      = 3'd2,
        CLS_LOAD   = 3'd3,
        CLS_STORE  = 3'd4,
        CLS_BRANCH = 3'd5,
        CLS_JAL    = 3'd6
    } cls_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_RFN = 2'b10;
    localparam logic [1:0] ALU_IFN = 2'b11;

    // CLS_NONE marks an illegal opcode.
    function automatic cls_t decode_class(input logic [6:0] opc);
        cls_t c;
        case (opc)
            OPC_R:      c = CLS_R;
            OPC_I:      c = CLS_I;
            OPC_LOAD:   c = CLS_LOAD;
            OPC_STORE:  c = CLS_STORE;
            OPC_BRANCH: c = CLS_BRANCH;
`ifdef RV_CTRL_JAL_EN
            OPC_JAL:    c = CLS_JAL;
`endif
            default:    c = CLS_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rv_multicycle_control_if.sv
// Control bundle between the multi-cycle controller (master) and the datapath/memories (slave).
// jump/link are always present; they only toggle when RV_CTRL_JAL_EN is defined.
interface rv_multicycle_control_if #(
    parameter int ALUOP_W = 2
);
    logic [6:0]         opcode;
    logic               imem_ack;
    logic               dmem_ack;
    logic               imem_req;
    logic               dmem_req;
    logic               dmem_we;
    logic               ir_write;
    logic               pc_write;
    logic               reg_write;
    logic               mem_to_reg;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               branch;
    logic               jump;
    logic               link;
    logic               retire;
    logic               fault;

    modport master (
        input  opcode, imem_ack, dmem_ack,
        output imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_write,
               mem_to_reg, alu_src, alu_op, branch, jump, link, retire, fault
    );

    modport slave (
        output opcode, imem_ack, dmem_ack,
        input  imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_write,
               mem_to_reg, alu_src, alu_op, branch, jump, link, retire, fault
    );

endinterface

// File: rtl/rv_ctrl_wait_timer.sv
// Memory wait counter: clears on state change, counts unacknowledged cycles, saturates at all-ones.
// expired flags the cycle in which the count would reach all-ones with no ack.
module rv_ctrl_wait_timer
    import rv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

    logic [TIMEOUT_W-1:0] count_reg;
    logic [TIMEOUT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (run && (count_reg != CNT_MAX)) begin
            count_next = count_reg + 1'b1;
        end
    end

    assign expired = run && (count_reg == (CNT_MAX - 1'b1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/rv_multicycle_control.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB with ack handshakes, wait timeout and sticky FAULT.
// Define RV_CTRL_JAL_EN to make JAL legal and drive jump/link.
module rv_multicycle_control
    import rv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_W = 4,
    parameter int ALUOP_W   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    rv_multicycle_control_if.master bus
);

    logic [2:0] state_reg;
    logic [2:0] state_next;
    cls_t       cls_reg;
    cls_t       cls_next;
    logic       ack_here;
    logic       timer_run;
    logic       timer_clear;
    logic       expired;
    logic [1:0] alu_op2;
    logic       in_alu_phase;

    assign ack_here = ((state_reg == ST_FETCH) && bus.imem_ack) ||
                      ((state_reg == ST_MEM)   && bus.dmem_ack);
    assign timer_run   = ((state_reg == ST_FETCH) || (state_reg == ST_MEM)) && !ack_here;
    assign timer_clear = (state_next != state_reg);

    rv_ctrl_wait_timer #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .run     (timer_run),
        .expired (expired)
    );

    always_comb begin
        state_next = state_reg;
        cls_next   = cls_reg;
        case (state_reg)
            ST_FETCH: begin
                if (ack_here)     state_next = ST_DECODE;
                else if (expired) state_next = ST_FAULT;
            end
            ST_DECODE: begin
                cls_next   = decode_class(bus.opcode);
                state_next = (cls_next == CLS_NONE) ? ST_FAULT : ST_EXEC;
            end
            ST_EXEC: begin
                case (cls_reg)
                    CLS_R, CLS_I, CLS_JAL: state_next = ST_WB;
                    CLS_LOAD, CLS_STORE:   state_next = ST_MEM;
                    CLS_BRANCH:            state_next = ST_FETCH;
                    default:               state_next = ST_FAULT;
                endcase
            end
            ST_MEM: begin
                if (ack_here)     state_next = (cls_reg == CLS_LOAD) ? ST_WB : ST_FETCH;
                else if (expired) state_next = ST_FAULT;
            end
            ST_WB:    state_next = ST_FETCH;
            default:  state_next = ST_FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_FETCH;
            cls_reg   <= CLS_NONE;
        end else begin
            state_reg <= state_next;
            cls_reg   <= cls_next;
        end
    end

    // Operand select and ALU op are class-driven and held from EXEC to WB.
    assign in_alu_phase = (state_reg == ST_EXEC) || (state_reg == ST_MEM) || (state_reg == ST_WB);

    always_comb begin
        alu_op2     = ALU_ADD;
        bus.alu_src = 1'b0;
        if (in_alu_phase) begin
            case (cls_reg)
                CLS_R:      alu_op2 = ALU_RFN;
                CLS_I:      alu_op2 = ALU_IFN;
                CLS_BRANCH: alu_op2 = ALU_SUB;
                default:    alu_op2 = ALU_ADD;
            endcase
            bus.alu_src = (cls_reg == CLS_I) || (cls_reg == CLS_LOAD) || (cls_reg == CLS_STORE);
        end
    end

    assign bus.alu_op[1:0] = alu_op2;

    generate
        for (genvar gi = 2; gi < ALUOP_W; gi++) begin : g_alu_op_hi
            assign bus.alu_op[gi] = 1'b0;
        end
    endgenerate

    always_comb begin
        bus.imem_req   = (state_reg == ST_FETCH);
        bus.ir_write   = (state_reg == ST_FETCH) && bus.imem_ack;
        bus.pc_write   = (state_reg == ST_FETCH) && bus.imem_ack;
        bus.dmem_req   = (state_reg == ST_MEM);
        bus.dmem_we    = (state_reg == ST_MEM) && (cls_reg == CLS_STORE);
        bus.reg_write  = (state_reg == ST_WB);
        bus.mem_to_reg = (state_reg == ST_WB) && (cls_reg == CLS_LOAD);
        bus.branch     = (state_reg == ST_EXEC) && (cls_reg == CLS_BRANCH);
        bus.retire     = ((state_reg == ST_EXEC) && (cls_reg == CLS_BRANCH)) ||
                         ((state_reg == ST_MEM) && (cls_reg == CLS_STORE) && bus.dmem_ack) ||
                         (state_reg == ST_WB);
        bus.fault      = (state_reg == ST_FAULT);
`ifdef RV_CTRL_JAL_EN
        bus.jump       = (state_reg == ST_EXEC) && (cls_reg == CLS_JAL);
        bus.link       = (state_reg == ST_WB) && (cls_reg == CLS_JAL);
`else
        bus.jump       = 1'b0;
        bus.link       = 1'b0;
`endif
    end

endmodule

// File: tb/tb_rv_multicycle_control.sv
// Directed bench for rv_multicycle_control: per-instruction phase model checked every cycle, plus literal latency pins.
// JAL expectations follow RV_CTRL_JAL_EN.
module tb_rv_multicycle_control;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv_multicycle_control_if #(.ALUOP_W(3)) bus ();

    rv_multicycle_control #(
        .TIMEOUT_W (4),
        .ALUOP_W   (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [15:0] IREQ = 16'h8000;
    localparam logic [15:0] DREQ = 16'h4000;
    localparam logic [15:0] DWE  = 16'h2000;
    localparam logic [15:0] IRW  = 16'h1000;
    localparam logic [15:0] PCW  = 16'h0800;
    localparam logic [15:0] RW   = 16'h0400;
    localparam logic [15:0] M2R  = 16'h0200;
    localparam logic [15:0] SRC  = 16'h0100;
    localparam logic [15:0] BR   = 16'h0010;
    localparam logic [15:0] JMP  = 16'h0008;
    localparam logic [15:0] LNK  = 16'h0004;
    localparam logic [15:0] RET  = 16'h0002;
    localparam logic [15:0] FLT  = 16'h0001;

    int          total = 0;
    int          bad   = 0;
    logic        check_en = 1'b0;
    logic [15:0] exp_vec = '0;
    string       tag = "idle";
    int          instr_cyc;
    int          instr_lat;

    function automatic logic [15:0] aop(input logic [1:0] v);
        return {8'b0, 1'b0, v, 5'b0};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_write, bus.pc_write,
                bus.reg_write, bus.mem_to_reg, bus.alu_src, bus.alu_op,
                bus.branch, bus.jump, bus.link, bus.retire, bus.fault};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] junk();
        return 7'($urandom);
    endfunction

    // 0 illegal, 1 R, 2 I, 3 LOAD, 4 STORE, 5 BRANCH, 6 JAL
    function automatic int kind(input logic [6:0] o);
        case (o)
            7'b0110011: return 1;
            7'b0010011: return 2;
            7'b0000011: return 3;
            7'b0100011: return 4;
            7'b1100011: return 5;
`ifdef RV_CTRL_JAL_EN
            7'b1101111: return 6;
`endif
            default:    return 0;
        endcase
    endfunction

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, got, want, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (check_en) check(tag, dut_vec(), exp_vec);
        end
    endtask

    task automatic step(input logic ia, input logic da, input logic [6:0] opc,
                        input logic [15:0] e, input string nm);
        bus.imem_ack = ia;
        bus.dmem_ack = da;
        bus.opcode   = opc;
        exp_vec      = e;
        tag          = nm;
        check_en     = 1'b1;
        instr_cyc++;
        #1;
        if (bus.retire && (instr_lat < 0)) instr_lat = instr_cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic fault_cycles(input int n, input string nm);
        for (int c = 0; c < n; c++) step(rb(), rb(), junk(), FLT, {nm, ":fault"});
    endtask

    task automatic do_reset(input string nm);
        check_en     = 1'b0;
        rst_n        = 1'b0;
        bus.imem_ack = 1'b1;
        bus.dmem_ack = 1'b1;
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        #1;
        check({nm, ":rst_vec"}, dut_vec(), IREQ);
    endtask

    // iw/dw: unacknowledged cycles before the ack; 15 or more means no ack at all.
    task automatic run_instr(input logic [6:0] opc, input int iw, input int dw, input string nm);
        int          k;
        logic        src;
        logic [1:0]  a;
        logic [15:0] base;
        instr_cyc = 0;
        instr_lat = -1;
        k = kind(opc);
        for (int c = 0; c < iw && c < 15; c++) step(1'b0, rb(), junk(), IREQ, {nm, ":fetch_wait"});
        if (iw >= 15) begin
            fault_cycles(4, nm);
            return;
        end
        step(1'b1, rb(), junk(), IREQ | IRW | PCW, {nm, ":fetch"});
        step(rb(), rb(), opc, 16'h0000, {nm, ":decode"});
        if (k == 0) begin
            fault_cycles(20, nm);
            return;
        end
        src  = (k == 2) || (k == 3) || (k == 4);
        a    = (k == 1) ? 2'b10 : (k == 2) ? 2'b11 : (k == 5) ? 2'b01 : 2'b00;
        base = (src ? SRC : 16'h0) | aop(a);
        case (k)
            5: step(rb(), rb(), junk(), base | BR | RET, {nm, ":exec"});
            6: begin
                step(rb(), rb(), junk(), base | JMP, {nm, ":exec"});
                step(rb(), rb(), junk(), base | RW | LNK | RET, {nm, ":wb"});
            end
            1, 2: begin
                step(rb(), rb(), junk(), base, {nm, ":exec"});
                step(rb(), rb(), junk(), base | RW | RET, {nm, ":wb"});
            end
            default: begin
                step(rb(), rb(), junk(), base, {nm, ":exec"});
                base = base | DREQ | ((k == 4) ? DWE : 16'h0);
                for (int c = 0; c < dw && c < 15; c++) step(rb(), 1'b0, junk(), base, {nm, ":mem_wait"});
                if (dw >= 15) begin
                    fault_cycles(4, nm);
                    return;
                end
                step(rb(), 1'b1, junk(), base | ((k == 4) ? RET : 16'h0), {nm, ":mem"});
                if (k == 3)
                    step(rb(), rb(), junk(), (base & ~(DREQ | DWE)) | RW | M2R | RET, {nm, ":wb"});
            end
        endcase
    endtask

    initial begin
        bus.opcode   = '0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        fork
            compare_loop();
        join_none

        do_reset("init");
        run_instr(7'b0110011, 0, 0, "R");
        check("lat_R", 16'(instr_lat), 16'd4);
        run_instr(7'b0010011, 0, 0, "I");
        check("lat_I", 16'(instr_lat), 16'd4);
        run_instr(7'b0000011, 0, 3, "LOAD_dw3");
        check("lat_LOAD_dw3", 16'(instr_lat), 16'd8);
        run_instr(7'b0100011, 0, 0, "STORE");
        check("lat_STORE", 16'(instr_lat), 16'd4);
        run_instr(7'b1100011, 0, 0, "BRANCH");
        check("lat_BRANCH", 16'(instr_lat), 16'd3);
        run_instr(7'b0000011, 2, 0, "LOAD_iw2");
        check("lat_LOAD_iw2", 16'(instr_lat), 16'd7);
        run_instr(7'b0110011, 14, 0, "R_ack15");
        check("lat_R_ack15", 16'(instr_lat), 16'd18);
        run_instr(7'b0100011, 0, 14, "STORE_ack15");
        check("lat_STORE_ack15", 16'(instr_lat), 16'd18);

        run_instr(7'b1111111, 0, 0, "ILLEGAL");
        do_reset("after_illegal");
        run_instr(7'b0110011, 15, 0, "IMEM_TO");
        do_reset("after_imem_to");
        run_instr(7'b0100011, 0, 15, "DMEM_TO");
        do_reset("after_dmem_to");

        instr_cyc = 0;
        instr_lat = -1;
        step(1'b1, 1'b0, junk(), IREQ | IRW | PCW, "MIDMEM:fetch");
        step(1'b0, 1'b0, 7'b0000011, 16'h0000, "MIDMEM:decode");
        step(1'b0, 1'b0, junk(), SRC, "MIDMEM:exec");
        step(1'b0, 1'b0, junk(), SRC | DREQ, "MIDMEM:mem_wait");
        step(1'b0, 1'b0, junk(), SRC | DREQ, "MIDMEM:mem_wait");
        do_reset("after_midmem");

        run_instr(7'b1101111, 0, 0, "JAL");
`ifdef RV_CTRL_JAL_EN
        check("lat_JAL", 16'(instr_lat), 16'd4);
`else
        do_reset("after_jal");
`endif
        run_instr(7'b1100011, 1, 0, "BRANCH_iw1");
        check("lat_BRANCH_iw1", 16'(instr_lat), 16'd4);

        check_en = 1'b0;
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv_multicycle_control.md
# rv_multicycle_control

Multi-cycle control FSM for the RISC-V datapath. It sequences each instruction through FETCH, DECODE, EXEC, MEM and WB with ready/ack handshakes to instruction and data memory, in place of a single-cycle opcode decode. It adds I-type ALU support, memory wait-state tolerance with a timeout, a sticky fault on illegal opcodes or memory timeout, and an optional JAL path. It sits between the instruction register and the datapath muxes and enables.

## Interface
- TIMEOUT_W, 4: width of the memory wait counter; timeout after 2^TIMEOUT_W-1 unacknowledged cycles.
- ALUOP_W, 2: alu_op width (min 2); bits above [1:0] are driven 0.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- opcode  in  7  instruction[6:0] from the IR; sampled only in DECODE.
- imem_ack  in  1  instruction memory read done; ignored outside FETCH.
- dmem_ack  in  1  data memory access done; ignored outside MEM.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  store qualifier for dmem_req.
- ir_write, pc_write  out  1 each  IR load / PC+4 update strobes.
- reg_write  out  1  register file write strobe.
- mem_to_reg, alu_src  out  1 each  writeback and ALU operand-B selects.
- alu_op  out  ALUOP_W  00 add, 01 compare/sub, 10 R-funct, 11 I-funct.
- branch  out  1  branch-evaluate strobe.
- jump, link  out  1 each  JAL strobes (see Configuration).
- retire  out  1  one-cycle pulse at instruction completion.
- fault  out  1  sticky error flag.

## Operation
- Instruction classes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111 (macro-gated). The class register is latched in DECODE.
- FETCH: imem_req=1. On imem_ack, ir_write=1 and pc_write=1 in the same cycle, then go to DECODE.
- DECODE: a legal opcode goes to EXEC; any other opcode goes to FAULT.
- EXEC: R and I go to WB. LOAD and STORE go to MEM. BRANCH asserts branch=1 and retire=1, then returns to FETCH.
- MEM: dmem_req=1, with dmem_we=1 for STORE. On dmem_ack, LOAD goes to WB; STORE asserts retire=1 and goes to FETCH.
- WB: reg_write=1, with mem_to_reg=1 for LOAD only. Asserts retire=1, then goes to FETCH.
- alu_src=1 for I, LOAD and STORE. alu_src and alu_op hold from EXEC through WB.
- FAULT: absorbing state with fault=1. All strobes and requests are 0. Only reset leaves it.
- Wait counter: runs in FETCH and MEM while no ack is present, and clears on every state change. If the counter reaches all-ones without an ack, the next state is FAULT. An ack in the saturating cycle wins over the timeout.

## Timing
- All outputs are combinational decodes of the state register, the class register and the ack inputs. No input-to-output path exists except ack to strobe.
- Reset (any state, including mid-MEM) leaves state=FETCH, class cleared, counter 0 and fault 0. The resulting output values are imem_req=1 and all other outputs 0.
- Latency with a zero-wait ack, from the first FETCH cycle to retire:
  - BRANCH: 3 cycles.
  - R, I and STORE: 4 cycles.
  - LOAD: 5 cycles.
  - JAL: 4 cycles.
- Each wait cycle adds 1 to the latency.
- Requests stay high until ack. A request is never withdrawn before ack, except by a timeout into FAULT or by reset.

## Configuration
- RV_CTRL_JAL_EN defined:
  - JAL is legal.
  - EXEC asserts jump=1 with alu_op=00, then goes to WB.
  - WB asserts reg_write=1, link=1 and mem_to_reg=0.
- RV_CTRL_JAL_EN undefined:
  - 1101111 is illegal and goes to FAULT.
  - jump and link are tied to 0; the ports remain present.

## Structure
- Package rv_ctrl_pkg holds the opcode constants, the state encoding (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5, 3 bits), the class encoding and the alu_op codes.
- Sub-module rv_ctrl_wait_timer (TIMEOUT_W) holds the clear/count/saturate counter and outputs expired.

## Test plan
- R-type 0110011, imem_ack in the first FETCH cycle: reg_write=1 in cycle 4, retire in cycle 4, alu_op=10, alu_src=0, back in FETCH at cycle 5.
- LOAD with dmem_ack delayed 3 cycles: dmem_req high for 4 cycles with dmem_we=0; WB asserts mem_to_reg=1 and reg_write=1; total latency 8.
- STORE then BRANCH back to back: STORE gives dmem_we=1 and no reg_write, retire at cycle 4. BRANCH gives branch=1 in its EXEC, retire at cycle 3.
- Opcode 1111111 in DECODE: fault=1 from the next cycle and holds for 20 cycles. rst_n low for 1 edge gives fault=0 and imem_req=1.
- TIMEOUT_W=4 with imem_ack never asserted: FAULT entered after 15 FETCH cycles. Repeat with ack in cycle 15: no fault, DECODE entered.
- JAL 1101111:
  - RV_CTRL_JAL_EN defined: jump=1 in EXEC, then link=1 and reg_write=1 in WB.
  - RV_CTRL_JAL_EN undefined: fault=1.
